// File: rtl/bla_serial_sub_if.sv
// bla_serial_sub_if: operand/result handshake bundle for bla_serial_sub
//   master drives a_in, b_in, bin, in_valid, out_ready
//   slave drives in_ready, d_out, bout, ovf, zero, out_valid
interface bla_serial_sub_if #(parameter int NIBBLES = 4);
    localparam int W = 4 * NIBBLES;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic         bin;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] d_out;
    logic         bout;
    logic         ovf;
    logic         zero;
    logic         out_valid;
    logic         out_ready;
    modport master (output a_in, b_in, bin, in_valid, out_ready,
                    input  in_ready, d_out, bout, ovf, zero, out_valid);
    modport slave  (input  a_in, b_in, bin, in_valid, out_ready,
                    output in_ready, d_out, bout, ovf, zero, out_valid);
endinterface

// File: rtl/bla_serial_sub.sv
// bla_serial_sub: nibble-serial subtractor a - b - bin, one 4-bit borrow-lookahead slice per cycle
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : slave side of bla_serial_sub_if (operand in / result out handshakes)
module bla_serial_sub #(parameter int NIBBLES = 4) (
    input logic         clk,
    input logic         reset,
    bla_serial_sub_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int KW = NIBBLES > 1 ? $clog2(NIBBLES) : 1;
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t        state;
    logic [W-1:0]  a_r, b_r, res_r;
    logic          brw;
    logic [KW-1:0] k;
    logic [3:0]    an, bn, g, p, d_n;
    logic [4:0]    c;
    assign an = a_r[{k, 2'b00} +: 4];
    assign bn = b_r[{k, 2'b00} +: 4];
    assign g  = ~an & bn;
    assign p  = ~(an ^ bn);
    // flat sum-of-products borrows so the slice has no ripple chain
    always_comb begin
        c    = '0;
        c[0] = brw;
        c[1] = g[0] | (p[0] & brw);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & brw);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & brw);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & brw);
    end
    assign d_n = an ^ bn ^ c[3:0];
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            a_r   <= '0;
            b_r   <= '0;
            res_r <= '0;
            brw   <= 1'b0;
            k     <= '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    a_r   <= bus.a_in;
                    b_r   <= bus.b_in;
                    brw   <= bus.bin;
                    k     <= '0;
                    state <= CALC;
                end
                CALC: begin
                    res_r[{k, 2'b00} +: 4] <= d_n;
                    brw <= c[4];
                    // index parks on the last nibble; it is cleared on the next accept
                    if (k == KW'(NIBBLES - 1)) state <= DONE;
                    else k <= k + 1'b1;
                end
                DONE: if (bus.out_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
    // outputs decode straight from registers, so they are glitch-free and forced low outside DONE
    assign bus.in_ready  = state == IDLE;
    assign bus.out_valid = state == DONE;
    assign bus.d_out     = state == DONE ? res_r : '0;
    assign bus.bout      = state == DONE && brw;
    assign bus.zero      = state == DONE && res_r == '0;
    assign bus.ovf       = state == DONE && a_r[W-1] != b_r[W-1] && res_r[W-1] != a_r[W-1];
endmodule

// File: tb/tb_bla_serial_sub.sv
// tb_bla_serial_sub: directed table plus handshake/reset sequences for bla_serial_sub
module tb_bla_serial_sub;
    logic clk = 1'b0;
    logic reset = 1'b0;
    int   passed = 0;
    int   total  = 0;
    bla_serial_sub_if #(.NIBBLES(4)) bus ();
    bla_serial_sub #(.NIBBLES(4)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a, b;
        logic        bin;
        logic [15:0] d;
        logic        bout, ovf, zero;
    } vec_t;
    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic start(input logic [15:0] a, input logic [15:0] b, input logic bi);
        @(negedge clk);
        bus.a_in = a; bus.b_in = b; bus.bin = bi; bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    // counts edges from the accept edge until out_valid, bounded
    task automatic wait_done(output int cyc);
        cyc = 1;
        while (!bus.out_valid && cyc < 20) begin
            @(posedge clk);
            #1;
            if (!bus.out_valid) cyc++;
        end
    endtask

    task automatic release_result();
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [15:0] held;
        bus.a_in = '0; bus.b_in = '0; bus.bin = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{16'h0005, 16'h0004, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0, 1'b0, 1'b0};

        #12;
        check("rst in_ready", bus.in_ready, 1);
        check("rst out_valid", bus.out_valid, 0);
        check("rst d_out", bus.d_out, 0);
        check("rst flags", {bus.bout, bus.ovf, bus.zero}, 0);
        @(negedge clk);
        reset = 1'b1;

        foreach (vecs[i]) begin
            start(vecs[i].a, vecs[i].b, vecs[i].bin);
            if (i == 0) begin
                check("calc in_ready", bus.in_ready, 0);
                check("calc out_valid", bus.out_valid, 0);
                check("calc d_out", bus.d_out, 0);
            end
            wait_done(cyc);
            check($sformatf("v%0d latency", i), cyc, 4);
            check($sformatf("v%0d d_out", i), bus.d_out, vecs[i].d);
            check($sformatf("v%0d bout", i), bus.bout, vecs[i].bout);
            check($sformatf("v%0d ovf", i), bus.ovf, vecs[i].ovf);
            check($sformatf("v%0d zero", i), bus.zero, vecs[i].zero);
            release_result();
            check($sformatf("v%0d idle out_valid", i), bus.out_valid, 0);
            check($sformatf("v%0d idle in_ready", i), bus.in_ready, 1);
        end

        // backpressure with a stray in_valid pulse in DONE
        start(16'h1234, 16'h0234, 1'b0);
        wait_done(cyc);
        check("bp latency", cyc, 4);
        held = bus.d_out;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            bus.in_valid = (n == 1);
            bus.a_in = 16'hFFFF; bus.b_in = 16'h0001; bus.bin = 1'b1;
            @(posedge clk);
            #1;
            check($sformatf("bp%0d d_out", n), bus.d_out, 16'h1000);
            check($sformatf("bp%0d out_valid", n), bus.out_valid, 1);
            check($sformatf("bp%0d in_ready", n), bus.in_ready, 0);
            check($sformatf("bp%0d flags", n), {bus.bout, bus.ovf, bus.zero}, 0);
        end
        check("bp hold", bus.d_out, held);
        @(negedge clk);
        bus.in_valid = 1'b0;
        release_result();
        check("bp in_ready after", bus.in_ready, 1);
        check("bp out_valid after", bus.out_valid, 0);
        @(posedge clk);
        #1;
        check("bp no reaccept", bus.in_ready, 1);

        // reset during the second CALC cycle
        start(16'h1234, 16'h0234, 1'b0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("mid rst in_ready", bus.in_ready, 1);
        check("mid rst out_valid", bus.out_valid, 0);
        check("mid rst d_out", bus.d_out, 0);
        check("mid rst flags", {bus.bout, bus.ovf, bus.zero}, 0);
        repeat (5) @(posedge clk);
        #1;
        check("mid rst hold out_valid", bus.out_valid, 0);
        @(negedge clk);
        reset = 1'b1;
        start(16'h0010, 16'h0001, 1'b0);
        wait_done(cyc);
        check("post rst latency", cyc, 4);
        check("post rst d_out", bus.d_out, 16'h000F);
        check("post rst bout", bus.bout, 0);
        release_result();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/bla_serial_sub.md
BLA_SERIAL_SUB -- requirements
Module: bla_serial_sub

Interface
REQ-001 The block SHALL have parameter NIBBLES, default 4, giving the number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 The block SHALL have port clk, input, 1, the single clock; every register SHALL update on its rising edge.
REQ-003 The block SHALL have port reset, input, 1: asynchronous, active-low reset (0 = reset asserted).
REQ-004 The block SHALL have port a_in, input, W: minuend.
REQ-005 The block SHALL have port b_in, input, W: subtrahend.
REQ-006 The block SHALL have port bin, input, 1: borrow-in.
REQ-007 The block SHALL have port in_valid, input, 1: operands valid.
REQ-008 The block SHALL have port in_ready, output, 1: block accepts operands.
REQ-009 The block SHALL have port d_out, output, W: difference a - b - bin.
REQ-010 The block SHALL have port bout, output, 1: borrow-out from the MSB slice.
REQ-011 The block SHALL have port ovf, output, 1: two's-complement signed overflow.
REQ-012 The block SHALL have port zero, output, 1: d_out == 0.
REQ-013 The block SHALL have port out_valid, output, 1: result valid.
REQ-014 The block SHALL have port out_ready, input, 1: consumer accepts the result.

Function
REQ-015 The block SHALL implement an FSM with three states: IDLE, CALC and DONE.
REQ-016 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-017 In IDLE, when in_valid = 1 at a clk edge (accept):
- a_in, b_in and bin SHALL be registered;
- the nibble index SHALL be cleared to 0;
- the state SHALL go to CALC.
REQ-018 In IDLE with in_valid = 0, the state SHALL remain IDLE.
REQ-019 Each CALC cycle SHALL process the nibble at the current index k using a 4-bit borrow-lookahead slice:
- G_i = ~a_i & b_i, P_i = ~(a_i ^ b_i);
- borrow_(i+1) = G_i | (P_i & borrow_i), with borrow_0 = the registered borrow;
- d_i = a_i ^ b_i ^ borrow_i.
REQ-020 Slice borrows SHALL be fully unrolled (non-recursive sum-of-products) within the nibble.
REQ-021 At each CALC edge:
- nibble k of the result register SHALL be written;
- the registered borrow SHALL take the slice borrow-out;
- k SHALL increment.
REQ-022 After the edge that processes k = NIBBLES-1, the state SHALL go to DONE, giving out_valid exactly NIBBLES cycles after the accept edge.
REQ-023 In DONE:
- bout SHALL equal the final registered borrow;
- zero SHALL be 1 iff all W result bits are 0;
- ovf SHALL be 1 iff a[W-1] != b[W-1] and d_out[W-1] != a[W-1].
REQ-024 In DONE with out_ready = 0, d_out, bout, ovf, zero and out_valid SHALL hold stable, with no limit on the wait.
REQ-025 In DONE with out_ready = 1 at an edge, the state SHALL go to IDLE, and in_ready SHALL rise on the following cycle (no same-cycle re-accept).
REQ-026 in_valid asserted during CALC or DONE SHALL be ignored and SHALL NOT alter the registered operands.
REQ-027 Outside DONE, d_out, bout, ovf and zero SHALL be driven 0.
REQ-028 The nibble index SHALL never exceed NIBBLES-1, and no further index update SHALL occur after the last nibble.

Reset
REQ-029 While reset = 0, regardless of clk, the state SHALL be IDLE and the operand, result, borrow and index registers SHALL be 0.
REQ-030 During reset, outputs SHALL be in_ready = 1, out_valid = 0, d_out = 0, bout = 0, ovf = 0 and zero = 0.
REQ-031 Reset asserted in CALC or DONE SHALL abort the operation with no partial result emitted; after release, the first edge with in_valid = 1 SHALL accept a new operation.

Verification
REQ-032 Basic subtract: a = 0x1234, b = 0x0234, bin = 0 -> out_valid 4 cycles after accept; d_out = 0x1000, bout = 0, ovf = 0, zero = 0.
REQ-033 Underflow: a = 0x0000, b = 0x0001, bin = 0 -> d_out = 0xFFFF, bout = 1, ovf = 0, zero = 0 (borrow ripples across all nibbles).
REQ-034 Signed overflow: a = 0x8000, b = 0x0001, bin = 0 -> d_out = 0x7FFF, bout = 0, ovf = 1.
REQ-035 Borrow-in and zero result: a = 0x0005, b = 0x0004, bin = 1 -> d_out = 0x0000, zero = 1, bout = 0.
REQ-036 Backpressure: out_ready = 0 for 3 cycles in DONE plus an in_valid pulse with new operands -> outputs unchanged, in_ready = 0, new operands not taken; out_ready = 1 -> IDLE, and in_ready = 1 on the next cycle.
REQ-037 Reset mid-operation: reset = 0 in the 2nd CALC cycle -> all outputs 0 and in_ready = 1 immediately; after release, a = 0x0010, b = 0x0001 -> d_out = 0x000F.
